image_scale_down_pow2: RTL and testbench
========================================

IMAGE_SCALE_DOWN_POW2 -- requirements
Module: image_scale_down_pow2

Interface
REQ-001 SHALL have parameter CH_WIDTH, default 8, bits per colour channel.
REQ-002 SHALL have parameter CHANNELS, default 3, channels packed per pixel; DATA_WIDTH = CH_WIDTH*CHANNELS, channel 0 in LSBs.
REQ-003 SHALL have parameter MAX_SHIFT, default 3, largest log2 decimation factor per axis (1..4).
REQ-004 clk_i  in  1  sole clock, all logic on rising edge.
REQ-005 rst_i  in  1  synchronous, active-high reset.
REQ-006 width_i  in  16  input active pixels per line, legal 1..65535.
REQ-007 height_i  in  16  input lines per frame, legal 1..65535.
REQ-008 h_shift_i  in  3  horizontal factor = 2^h_shift_i, legal 0..MAX_SHIFT.
REQ-009 v_shift_i  in  3  vertical factor = 2^v_shift_i, legal 0..MAX_SHIFT.
REQ-010 mode_i  in  1  0 = decimate (keep pixel), 1 = horizontal box average.
REQ-011 tdata_i  in  DATA_WIDTH  input pixel; tvalid_i  in  1  pixel qualifier; tuser_i  in  1  start-of-frame, meaningful only with tvalid_i.
REQ-012 tdata_o  out  DATA_WIDTH  output pixel; tvalid_o  out  1  output qualifier; tuser_o  out  1  first output pixel of frame; tlast_o  out  1  last output pixel of line.

Function
REQ-013 Block SHALL have no backpressure; every tvalid_i cycle accepts one pixel, gaps of any length allowed.
REQ-014 col_cnt SHALL count accepted pixels 0..width-1 and wrap to 0 after width-1; row_cnt SHALL advance on that wrap, wrapping to 0 after height-1.
REQ-015 tvalid_i with tuser_i SHALL force that pixel to col 0, row 0 regardless of counter state (resync); a line truncated this way produces no tlast_o.
REQ-016 width, height, h_shift, v_shift, mode SHALL be latched on every accepted pixel at col 0 row 0 and held for the whole frame; the latching pixel itself uses the new values.
REQ-017 Horizontal group = 2^h_shift consecutive pixels aligned to col 0; group ends when col_cnt low h_shift bits are all ones.
REQ-018 Row kept when row_cnt low v_shift bits are all ones (last row of each vertical group); other rows produce no output.
REQ-019 Trailing partial horizontal group (width not multiple of factor) SHALL be discarded; output width = floor(width/2^h_shift); same floor rule vertically.
REQ-020 Decimate mode: output = input pixel ending the group.
REQ-021 Average mode: per channel, accumulator of CH_WIDTH+MAX_SHIFT bits sums group pixels, output = sum >> h_shift (truncating, no rounding); accumulator cleared at group start so no state leaks across groups, lines or resync.
REQ-022 Shift 0 SHALL pass every pixel of every line in both modes (average = identity).
REQ-023 Output SHALL be registered, latency exactly 1 cycle from the group-ending tvalid_i to tvalid_o; tvalid_o high one cycle per output pixel.
REQ-024 tlast_o SHALL assert with the output pixel whose group ends at col floor(width/f)*f-1 of a kept row.
REQ-025 tuser_o SHALL assert with the first output pixel of the frame only (first kept row, first group).
REQ-026 width or height below factor SHALL produce no output for that axis; no tuser_o/tlast_o emitted.
REQ-027 tdata_o SHALL hold last output value when tvalid_o low; tuser_o and tlast_o SHALL be low whenever tvalid_o low.

Reset
REQ-028 On rst_i: col_cnt, row_cnt, accumulators = 0; tvalid_o, tuser_o, tlast_o = 0; tdata_o = 0; latched config = h_shift 0, v_shift 0, mode 0.
REQ-029 Reset mid-frame SHALL abandon the frame; next accepted pixel is col 0 row 0 with no residue from the old frame.

Verification
REQ-030 width 8, height 4, shifts 1/1, mode 0, pixel value = col+16*row, continuous valid -> 8 outputs: 0x11,0x13,0x15,0x17,0x31,0x33,0x35,0x37; tuser_o with 0x11; tlast_o with 0x17 and 0x37.
REQ-031 Same frame, mode 1, h_shift 2, v_shift 0, CH_WIDTH 8 all channels equal -> per line 2 outputs, row 0 gives 1 and 5 (sums 6>>2, 22>>2).
REQ-032 width 7, h_shift 1, mode 1, channel values 255 -> 3 outputs per line of 255, tlast_o on third, seventh pixel dropped, no overflow.
REQ-033 tvalid_i toggling every other cycle, shifts 0 -> each output exactly 1 cycle after its input, identical data.
REQ-034 tuser_i asserted at col 5 row 2 of width 8 frame -> counters restart, next outputs aligned to new col 0, tuser_o on first kept output, no tlast_o for truncated line.
REQ-035 rst_i pulsed mid-line during mode 1 accumulation -> all outputs 0 next cycle; following frame averages match golden model with no carried sum.

Source files
------------

// File: rtl/image_scale_down_pow2.sv
// Power-of-two image downscaler: decimate or horizontally box-average per 2^h x 2^v group.
// Latency 1 cycle from the group-ending input pixel; no backpressure, input gaps of any length accepted.
module image_scale_down_pow2 #(
    parameter int CH_WIDTH   = 8,
    parameter int CHANNELS   = 3,
    parameter int MAX_SHIFT  = 3,
    localparam int DATA_WIDTH = CH_WIDTH * CHANNELS
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [15:0]           width_i,
    input  logic [15:0]           height_i,
    input  logic [2:0]            h_shift_i,
    input  logic [2:0]            v_shift_i,
    input  logic                  mode_i,
    input  logic [DATA_WIDTH-1:0] tdata_i,
    input  logic                  tvalid_i,
    input  logic                  tuser_i,
    output logic [DATA_WIDTH-1:0] tdata_o,
    output logic                  tvalid_o,
    output logic                  tuser_o,
    output logic                  tlast_o
);

    localparam int ACC_W = CH_WIDTH + MAX_SHIFT;

    logic [15:0]      col_cnt, row_cnt, width_q, height_q;
    logic [2:0]       h_shift_q, v_shift_q;
    logic             mode_q;
    logic [ACC_W-1:0] acc_q [CHANNELS];

    logic [15:0]           col_e, row_e, width_e, height_e;
    logic [2:0]            h_e, v_e;
    logic                  mode_e, frame_start;
    logic [15:0]           hmask, vmask, last_col, col_next, row_next;
    logic                  group_start, group_end, row_keep, col_wrap, emit;
    logic [ACC_W-1:0]      sum [CHANNELS];
    logic [ACC_W-1:0]      avg_full [CHANNELS];
    logic [DATA_WIDTH-1:0] avg_dat, out_dat;

    always_comb begin
        // A start-of-frame flag overrides the counters; config is taken live on the frame's first pixel.
        col_e       = tuser_i ? 16'd0 : col_cnt;
        row_e       = tuser_i ? 16'd0 : row_cnt;
        frame_start = (col_e == 16'd0) && (row_e == 16'd0);
        width_e     = frame_start ? width_i   : width_q;
        height_e    = frame_start ? height_i  : height_q;
        h_e         = frame_start ? h_shift_i : h_shift_q;
        v_e         = frame_start ? v_shift_i : v_shift_q;
        mode_e      = frame_start ? mode_i    : mode_q;

        hmask       = ~(16'hFFFF << h_e);
        vmask       = ~(16'hFFFF << v_e);
        group_start = (col_e & hmask) == 16'd0;
        group_end   = (col_e & hmask) == hmask;
        row_keep    = (row_e & vmask) == vmask;
        last_col    = ((width_e >> h_e) << h_e) - 16'd1;
        emit        = tvalid_i && group_end && row_keep;

        col_wrap = (col_e == width_e - 16'd1);
        col_next = col_wrap ? 16'd0 : col_e + 16'd1;
        row_next = row_e;
        if (col_wrap)
            row_next = (row_e == height_e - 16'd1) ? 16'd0 : row_e + 16'd1;

        avg_dat = '0;
        for (int c = 0; c < CHANNELS; c++) begin
            sum[c]      = (group_start ? '0 : acc_q[c])
                        + ACC_W'(tdata_i[c*CH_WIDTH +: CH_WIDTH]);
            avg_full[c] = sum[c] >> h_e;
            avg_dat[c*CH_WIDTH +: CH_WIDTH] = avg_full[c][CH_WIDTH-1:0];
        end
        out_dat = mode_e ? avg_dat : tdata_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            col_cnt   <= '0;
            row_cnt   <= '0;
            width_q   <= 16'd1;
            height_q  <= 16'd1;
            h_shift_q <= '0;
            v_shift_q <= '0;
            mode_q    <= 1'b0;
            for (int c = 0; c < CHANNELS; c++)
                acc_q[c] <= '0;
            tdata_o   <= '0;
            tvalid_o  <= 1'b0;
            tuser_o   <= 1'b0;
            tlast_o   <= 1'b0;
        end else begin
            tvalid_o <= emit;
            tuser_o  <= emit && (row_e == vmask) && (col_e == hmask);
            tlast_o  <= emit && (col_e == last_col);
            if (emit)
                tdata_o <= out_dat;
            if (tvalid_i) begin
                col_cnt <= col_next;
                row_cnt <= row_next;
                for (int c = 0; c < CHANNELS; c++)
                    acc_q[c] <= sum[c];
                if (frame_start) begin
                    width_q   <= width_i;
                    height_q  <= height_i;
                    h_shift_q <= h_shift_i;
                    v_shift_q <= v_shift_i;
                    mode_q    <= mode_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_image_scale_down_pow2.sv
// Randomised and directed bench for image_scale_down_pow2 against a frame-level arithmetic model.
module tb_image_scale_down_pow2;

    localparam int CW = 8;
    localparam int CH = 3;
    localparam int DW = CW * CH;

    logic          clk = 1'b0;
    logic          rst_i;
    logic [15:0]   width_i, height_i;
    logic [2:0]    h_shift_i, v_shift_i;
    logic          mode_i;
    logic [DW-1:0] tdata_i;
    logic          tvalid_i, tuser_i;
    logic [DW-1:0] tdata_o;
    logic          tvalid_o, tuser_o, tlast_o;

    always #5 clk = ~clk;

    image_scale_down_pow2 #(.CH_WIDTH(CW), .CHANNELS(CH), .MAX_SHIFT(3)) dut (
        .clk_i(clk), .rst_i(rst_i), .width_i(width_i), .height_i(height_i),
        .h_shift_i(h_shift_i), .v_shift_i(v_shift_i), .mode_i(mode_i),
        .tdata_i(tdata_i), .tvalid_i(tvalid_i), .tuser_i(tuser_i),
        .tdata_o(tdata_o), .tvalid_o(tvalid_o), .tuser_o(tuser_o), .tlast_o(tlast_o)
    );

    int checks = 0;
    int failures = 0;
    bit chk_en = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: counts pixel positions with plain integers, sums each group, divides by the factor.
    int            mcol, mrow, mw, mh, mhs, mvs, f, fv;
    bit            mmode;
    int            gsum [CH];
    logic          exp_vld, exp_usr, exp_lst;
    logic [DW-1:0] exp_dat, od;

    always @(posedge clk) begin
        if (rst_i) begin
            mcol = 0; mrow = 0; mw = 1; mh = 1; mhs = 0; mvs = 0; mmode = 0;
            for (int c = 0; c < CH; c++) gsum[c] = 0;
            exp_vld = 0; exp_usr = 0; exp_lst = 0; exp_dat = '0;
        end else if (tvalid_i) begin
            if (tuser_i) begin mcol = 0; mrow = 0; end
            if (mcol == 0 && mrow == 0) begin
                mw = int'(width_i); mh = int'(height_i);
                mhs = int'(h_shift_i); mvs = int'(v_shift_i); mmode = mode_i;
            end
            f  = 1 << mhs;
            fv = 1 << mvs;
            if (mcol % f == 0)
                for (int c = 0; c < CH; c++) gsum[c] = 0;
            for (int c = 0; c < CH; c++) gsum[c] += int'(tdata_i[c*CW +: CW]);
            if ((mcol % f == f - 1) && (mrow % fv == fv - 1)) begin
                for (int c = 0; c < CH; c++)
                    od[c*CW +: CW] = mmode ? 8'(gsum[c] / f) : tdata_i[c*CW +: CW];
                exp_vld = 1;
                exp_dat = od;
                exp_usr = (mcol == f - 1) && (mrow == fv - 1);
                exp_lst = (mcol == (mw / f) * f - 1);
            end else begin
                exp_vld = 0; exp_usr = 0; exp_lst = 0;
            end
            mcol++;
            if (mcol == mw) begin
                mcol = 0;
                mrow++;
                if (mrow == mh) mrow = 0;
            end
        end else begin
            exp_vld = 0; exp_usr = 0; exp_lst = 0;
        end
    end

    logic [DW+1:0] cap[$];

    always @(negedge clk) begin
        if (chk_en) begin
            check("tvalid_o", 32'(tvalid_o), 32'(exp_vld));
            check("tuser_o",  32'(tuser_o),  32'(exp_usr));
            check("tlast_o",  32'(tlast_o),  32'(exp_lst));
            check("tdata_o",  32'(tdata_o),  32'(exp_dat));
            if (tvalid_o) cap.push_back({tuser_o, tlast_o, tdata_o});
        end
    end

    logic [15:0] cfg_w, cfg_h;
    logic [2:0]  cfg_hs, cfg_vs;
    logic        cfg_md;

    task automatic drive(input logic v, input logic u, input logic [DW-1:0] d);
        @(posedge clk);
        #2;
        tvalid_i = v; tuser_i = u; tdata_i = d;
        width_i = cfg_w; height_i = cfg_h; h_shift_i = cfg_hs; v_shift_i = cfg_vs; mode_i = cfg_md;
    endtask

    task automatic idle(input int n);
        repeat (n) drive(1'b0, 1'($urandom), DW'($urandom));
    endtask

    task automatic pulse_reset();
        @(posedge clk); #2; rst_i = 1'b1; tvalid_i = 1'b0;
        @(posedge clk); #2; rst_i = 1'b0;
    endtask

    // dmode: 0 = col+16*row pattern, 1 = random, 2 = all ones.
    task automatic frame(input int w, input int h, input int hs, input int vs, input bit md,
                         input int gap, input int dmode, input bit alt, input bit garble,
                         input int npix);
        int n;
        logic [DW-1:0] d;
        logic [7:0] pv;
        n = (npix < 0) ? w * h : npix;
        cfg_w = 16'(w); cfg_h = 16'(h); cfg_hs = 3'(hs); cfg_vs = 3'(vs); cfg_md = md;
        for (int k = 0; k < n; k++) begin
            if (alt && k != 0) idle(1);
            while (int'($urandom_range(99)) < gap) idle(1);
            pv = 8'((k % w) + 16 * (k / w));
            d = (dmode == 0) ? {CH{pv}} : (dmode == 1) ? DW'($urandom) : {DW{1'b1}};
            drive(1'b1, k == 0, d);
            if (garble) begin
                cfg_w = 16'($urandom_range(1, 20)); cfg_h = 16'($urandom_range(1, 9));
                cfg_hs = 3'($urandom_range(0, 3)); cfg_vs = 3'($urandom_range(0, 3));
                cfg_md = 1'($urandom);
            end
        end
    endtask

    logic [7:0] lit30 [8];

    initial begin
        lit30 = '{8'h11, 8'h13, 8'h15, 8'h17, 8'h31, 8'h33, 8'h35, 8'h37};
        rst_i = 1'b1; tvalid_i = 1'b0; tuser_i = 1'b0; tdata_i = '0;
        width_i = 16'd1; height_i = 16'd1; h_shift_i = '0; v_shift_i = '0; mode_i = 1'b0;
        cfg_w = 16'd1; cfg_h = 16'd1; cfg_hs = '0; cfg_vs = '0; cfg_md = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst_i = 1'b0;
        chk_en = 1;
        @(negedge clk);
        check("reset_tvalid", 32'(tvalid_o), 32'd0);
        check("reset_tdata",  32'(tdata_o),  32'd0);

        // 8x4 decimate by 2x2
        cap.delete();
        frame(8, 4, 1, 1, 1'b0, 0, 0, 1'b0, 1'b0, -1);
        idle(3);
        check("dec_count", 32'(cap.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap.size(); i++) begin
            check("dec_data", 32'(cap[i][DW-1:0]), 32'({CH{lit30[i]}}));
            check("dec_tuser", 32'(cap[i][DW+1]), 32'(i == 0));
            check("dec_tlast", 32'(cap[i][DW]), 32'(i == 3 || i == 7));
        end

        // 8x4 horizontal average by 4
        cap.delete();
        frame(8, 4, 2, 0, 1'b1, 0, 0, 1'b0, 1'b0, -1);
        idle(3);
        check("avg4_count", 32'(cap.size()), 32'd8);
        if (cap.size() == 8) begin
            check("avg4_r0g0", 32'(cap[0][DW-1:0]), 32'({CH{8'd1}}));
            check("avg4_r0g1", 32'(cap[1][DW-1:0]), 32'({CH{8'd5}}));
            check("avg4_r0_last", 32'(cap[1][DW]), 32'd1);
            check("avg4_r3g1", 32'(cap[7][DW-1:0]), 32'({CH{8'd53}}));
        end

        // width 7, full-scale average, trailing pixel discarded
        cap.delete();
        frame(7, 2, 1, 0, 1'b1, 0, 2, 1'b0, 1'b0, -1);
        idle(3);
        check("w7_count", 32'(cap.size()), 32'd6);
        for (int i = 0; i < 6 && i < cap.size(); i++) begin
            check("w7_data", 32'(cap[i][DW-1:0]), 32'({DW{1'b1}}));
            check("w7_tlast", 32'(cap[i][DW]), 32'(i == 2 || i == 5));
        end

        // shift 0 with alternating valid
        cap.delete();
        frame(4, 4, 0, 0, 1'b1, 0, 1, 1'b1, 1'b0, -1);
        idle(3);
        check("pass_count", 32'(cap.size()), 32'd16);

        // resync at col 5 row 2
        frame(8, 4, 1, 1, 1'b0, 0, 0, 1'b0, 1'b0, 8 * 2 + 5);
        cap.delete();
        frame(8, 4, 1, 1, 1'b0, 0, 0, 1'b0, 1'b0, -1);
        idle(3);
        check("resync_count", 32'(cap.size()), 32'd8);
        if (cap.size() > 0) begin
            check("resync_tuser", 32'(cap[0][DW+1]), 32'd1);
            check("resync_data", 32'(cap[0][DW-1:0]), 32'({CH{8'h11}}));
        end

        // reset in the middle of an averaging group
        frame(8, 4, 2, 0, 1'b1, 0, 1, 1'b0, 1'b0, 6);
        pulse_reset();
        @(negedge clk);
        check("midrst_tvalid", 32'(tvalid_o), 32'd0);
        check("midrst_tdata",  32'(tdata_o),  32'd0);
        frame(8, 4, 2, 0, 1'b1, 0, 1, 1'b0, 1'b0, -1);
        idle(2);

        repeat (40) begin
            int w, h;
            w = $urandom_range(1, 12);
            h = $urandom_range(1, 6);
            frame(w, h, $urandom_range(0, 3), $urandom_range(0, 3), 1'($urandom),
                  $urandom_range(0, 50), 1, 1'b0, 1'b1,
                  ($urandom_range(0, 4) == 0) ? $urandom_range(1, w * h) : -1);
            if ($urandom_range(0, 9) == 0) pulse_reset();
            idle($urandom_range(0, 3));
        end
        idle(3);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
